// File: rtl/pc_unit_if.sv
// Fetch-stage program counter bus: redirect/control requests in, fetch address and status out.
// master drives requests (pipeline control/debug side); slave is the pc unit.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              halt_req;
    logic              resume;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              pc_valid;
    logic              halted;
    logic              wrapped;
    logic [CNT_W-1:0]  advance_count;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, halt_req, resume,
        input  pc, pc_plus, pc_valid, halted, wrapped, advance_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, halt_req, resume,
        output pc, pc_plus, pc_valid, halted, wrapped, advance_count
    );
endinterface

// File: rtl/pc_unit.sv
// Registered program counter with branch/jump redirect, stall, halt/resume,
// sticky wrap flag and a saturating advance counter.
module pc_unit #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned STEP       = 1,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    typedef enum logic {StRun, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              wrapped_q, wrapped_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W:0]   pc_sum;
    logic              advance;

    // Extra MSB carries the overflow that feeds the wrap flag.
    assign pc_sum = {1'b0, pc_q} + (ADDR_W + 1)'(STEP);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        wrapped_d  = wrapped_q;
        advance    = 1'b0;
        unique case (state_q)
            StRun: begin
                pc_valid_d = 1'b1;
                if (!bus.stall) begin
                    if (bus.branch_taken) begin
                        pc_d    = bus.branch_target;
                        advance = 1'b1;
                    end else if (bus.jump) begin
                        pc_d    = bus.jump_target;
                        advance = 1'b1;
                    end else if (bus.halt_req) begin
                        state_d    = StHalt;
                        pc_valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_sum[ADDR_W-1:0];
                        advance = 1'b1;
                        if (pc_sum[ADDR_W]) wrapped_d = 1'b1;
                    end
                end
            end
            StHalt: begin
                if (bus.resume) begin
                    state_d    = StRun;
                    pc_valid_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
        count_d = (advance && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= ADDR_W'(RESET_ADDR);
            pc_valid_q <= 1'b0;
            wrapped_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            wrapped_q  <= wrapped_d;
            count_q    <= count_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus       = pc_sum[ADDR_W-1:0];
    assign bus.pc_valid      = pc_valid_q;
    assign bus.halted        = (state_q == StHalt);
    assign bus.wrapped       = wrapped_q;
    assign bus.advance_count = count_q;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised, registered program counter for the pipelined processor fetch stage; replaces the pass-through next-address stage.
- Holds the current fetch address and selects the next one from sequential increment, branch redirect and jump redirect.
- Supports stall, halt/resume, a sticky wrap-around flag and a saturating count of PC advances for the debug unit.

Parameters:
- ADDR_W, 7, width of pc and targets in bits (128-word instruction memory).
- STEP, 1, sequential increment, in address units (1 = word addressing, 4 = byte addressing).
- RESET_ADDR, 0, pc value loaded on reset. Must fit in ADDR_W bits.
- CNT_W, 16, width of advance_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit freeze; pc holds.
- branch_taken  in  1  branch resolved taken; load branch_target.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  jump decoded; load jump_target.
- jump_target  in  ADDR_W  jump destination.
- halt_req  in  1  halt instruction decoded.
- resume  in  1  leave halt (debug unit).
- pc  out  ADDR_W  current fetch address, registered.
- pc_plus  out  ADDR_W  pc+STEP, combinational, modulo 2^ADDR_W.
- pc_valid  out  1  registered; fetch at pc is live.
- halted  out  1  registered; state is HALT.
- wrapped  out  1  sticky flag; a sequential increment overflowed.
- advance_count  out  CNT_W  saturating count of pc updates.

Behaviour:
- Reset (synchronous, highest priority; takes effect at the next edge even mid-halt or mid-stall):
  - pc=RESET_ADDR, state=RUN, pc_valid=0, halted=0, wrapped=0, advance_count=0.
- pc_valid becomes 1 on the first edge with reset low while in RUN. It is 0 in HALT.
- FSM has two states, RUN and HALT. Per-edge priority in RUN:
  1. stall: pc, state and count hold. halt_req, branch_taken and jump are ignored this cycle.
  2. branch_taken: pc<=branch_target. Wins over jump, because the older instruction resolves later. Also wins over halt_req; state stays RUN.
  3. jump: pc<=jump_target. Wins over halt_req; state stays RUN.
  4. halt_req: pc holds, state<=HALT, halted<=1, pc_valid<=0.
  5. Otherwise: pc<=pc+STEP, truncated to ADDR_W.
- Latency is one cycle from request to new pc. There is no combinational path from inputs to pc.
- HALT state:
  - pc holds. stall, branch_taken, jump and halt_req are ignored.
  - resume=1 gives state<=RUN, halted<=0 and pc_valid<=1. pc stays unchanged on that edge; normal advance resumes on the next edge.
- wrapped: set when a sequential increment has pc+STEP >= 2^ADDR_W. It stays set until reset. Loads of branch or jump targets never set it.
- advance_count: +1 on every edge where pc is written by increment, branch or jump (not on reset). It saturates at 2^CNT_W-1.
- pc_plus is always pc+STEP mod 2^ADDR_W, including in HALT and during stall.

Test Plan:
- Reset release (defaults) -> pc 0,1,2,3 on successive edges; pc_valid=1 from the first edge; advance_count=3 after three edges.
- pc=5 plus stall for 3 cycles, then release -> pc stays 5 for 3 edges, then 6; count does not change during the stall.
- pc=10 with branch_taken=1, branch_target=40, jump=1, jump_target=99 on the same edge -> pc=40; next edge, no requests -> pc=41.
- pc=20, halt_req=1 -> pc=20, halted=1, pc_valid=0. Then jump=1, jump_target=3 while halted -> pc stays 20. Then resume -> pc=20, halted=0; next edge -> 21.
- Load jump_target=127 (wrapped stays 0), then one increment -> pc=0, wrapped=1. Then reset -> wrapped=0, pc=0.
- Reset asserted during HALT with stall=1 -> next edge pc=RESET_ADDR, halted=0, pc_valid=0, advance_count=0.
